// File: rtl/rs_ap_ctrl_join_tail_if.sv
// ap_ctrl handshake bundle between an upstream controller and a set of sinks.
// Upstream drives ap_start (if_write) and sinks drive ap_ready (if_read); the tail returns the rest.
interface rs_ap_ctrl_join_tail_if #(
    parameter int NUM_SINKS = 1
);
    logic                 if_write;
    logic                 if_full_n;
    logic [NUM_SINKS-1:0] if_empty_n;
    logic [NUM_SINKS-1:0] if_read;

    modport master (
        output if_write,
        output if_read,
        input  if_full_n,
        input  if_empty_n
    );

    modport slave (
        input  if_write,
        input  if_read,
        output if_full_n,
        output if_empty_n
    );
endinterface

// File: rtl/rs_ap_ctrl_join_tail.sv
// ap_ctrl tail: pipelines ap_start out to NUM_SINKS sinks, joins their ap_ready into one upstream
// ap_ready, and blanks every sink's ap_start for a grace window after each join.
module rs_ap_ctrl_join_tail #(
    parameter int GRACE_PERIOD = 4,
    parameter int TAIL_LEVEL   = 1,
    parameter int NUM_SINKS    = 1,
    parameter int COUNT_WIDTH  = 16,
    parameter     __REGION     = ""
) (
    input  logic                   clk,
    input  logic                   reset_n,
    rs_ap_ctrl_join_tail_if.slave  ctrl,
    output logic                   err_unexpected_ready,
    output logic [COUNT_WIDTH-1:0] txn_count
);

    localparam int MIN_GRACE = (2 * TAIL_LEVEL > 1) ? 2 * TAIL_LEVEL : 1;
    localparam int CNT_W     = $clog2(GRACE_PERIOD + 1);

    if (GRACE_PERIOD < MIN_GRACE) begin : g_badGrace
        $error("GRACE_PERIOD (%0d) must be at least %0d", GRACE_PERIOD, MIN_GRACE);
    end
    if (TAIL_LEVEL < 0 || TAIL_LEVEL > 8) begin : g_badTail
        $error("TAIL_LEVEL (%0d) must be within 0..8", TAIL_LEVEL);
    end
    if (NUM_SINKS < 1 || NUM_SINKS > 16) begin : g_badSinks
        $error("NUM_SINKS (%0d) must be within 1..16", NUM_SINKS);
    end
    if ($bits(__REGION) < 0) begin : g_badRegion
        $error("__REGION tag is malformed");
    end

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_t;

    state_t                 state_q;
    logic [CNT_W-1:0]       holdCnt_q;
    logic [NUM_SINKS-1:0]   done_q;
    logic [COUNT_WIDTH-1:0] txnCount_q;
    logic                   errFlag_q;

    logic                   startTail;
    logic                   joinNow;
    logic [NUM_SINKS-1:0]   sinkStart;
    logic [NUM_SINKS-1:0]   accept;

    // Matching delay lines on the start and ready paths; depth 0 collapses to wires.
    if (TAIL_LEVEL == 0) begin : g_noPipe
        assign startTail      = ctrl.if_write;
        assign ctrl.if_full_n = joinNow;
    end else begin : g_pipe
        logic [TAIL_LEVEL-1:0] startPipe_q;
        logic [TAIL_LEVEL-1:0] readyPipe_q;

        always_ff @(posedge clk) begin
            if (!reset_n) begin
                startPipe_q <= '0;
                readyPipe_q <= '0;
            end else begin
                startPipe_q[0] <= ctrl.if_write;
                readyPipe_q[0] <= joinNow;
                for (int k = 1; k < TAIL_LEVEL; k++) begin
                    startPipe_q[k] <= startPipe_q[k-1];
                    readyPipe_q[k] <= readyPipe_q[k-1];
                end
            end
        end

        assign startTail      = startPipe_q[TAIL_LEVEL-1];
        assign ctrl.if_full_n = readyPipe_q[TAIL_LEVEL-1];
    end

    assign sinkStart = {NUM_SINKS{startTail && (state_q == COLLECT)}} & ~done_q;
    assign accept    = ctrl.if_read & sinkStart;
    assign joinNow   = (state_q == COLLECT) && (&(done_q | accept));

    // Join bookkeeping; the hold counter runs independently of any stray ready seen meanwhile.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= COLLECT;
            holdCnt_q  <= '0;
            done_q     <= '0;
            txnCount_q <= '0;
            errFlag_q  <= 1'b0;
        end else begin
            if (|(ctrl.if_read & ~sinkStart)) begin
                errFlag_q <= 1'b1;
            end
            case (state_q)
                COLLECT: begin
                    if (joinNow) begin
                        done_q     <= '0;
                        state_q    <= HOLD;
                        holdCnt_q  <= CNT_W'(1);
                        txnCount_q <= txnCount_q + 1'b1;
                    end else begin
                        done_q <= done_q | accept;
                    end
                end
                HOLD: begin
                    if (holdCnt_q == CNT_W'(GRACE_PERIOD)) begin
                        state_q   <= COLLECT;
                        holdCnt_q <= '0;
                    end else begin
                        holdCnt_q <= holdCnt_q + 1'b1;
                    end
                end
                default: state_q <= COLLECT;
            endcase
        end
    end

    assign ctrl.if_empty_n      = sinkStart;
    assign err_unexpected_ready = errFlag_q;
    assign txn_count            = txnCount_q;

endmodule

// File: tb/tb_rs_ap_ctrl_join_tail.sv
// Bench for rs_ap_ctrl_join_tail: a directed staggered-join/hold/reset scenario followed by random
// traffic, all compared cycle by cycle against a history-based reference model.
module tb_rs_ap_ctrl_join_tail;

    localparam int NS = 3;
    localparam int TL = 2;
    localparam int GP = 4;
    localparam int CW = 3;

    logic          clk;
    logic          reset_n;
    logic          errOut;
    logic [CW-1:0] txnOut;

    rs_ap_ctrl_join_tail_if #(.NUM_SINKS(NS)) ctrl ();

    rs_ap_ctrl_join_tail #(
        .GRACE_PERIOD(GP),
        .TAIL_LEVEL  (TL),
        .NUM_SINKS   (NS),
        .COUNT_WIDTH (CW),
        .__REGION    ("tb")
    ) dut (
        .clk                 (clk),
        .reset_n             (reset_n),
        .ctrl                (ctrl),
        .err_unexpected_ready(errOut),
        .txn_count           (txnOut)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checkCount = 0;
    int errorCount = 0;

    // Reference model: input histories since the last reset plus the cycle of the last join.
    bit writeHist[$];
    bit joinHist[$];
    bit modelDone[NS];
    int cycleNo  = 0;
    int lastJoin = -1000;
    bit modelErr = 1'b0;
    int modelTxn = 0;
    bit checksOn = 1'b0;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cycleNo, observed, expected);
        end
    endtask

    task automatic modelReset();
        writeHist.delete();
        joinHist.delete();
        for (int i = 0; i < NS; i++) modelDone[i] = 1'b0;
        lastJoin = -1000;
        modelErr = 1'b0;
        modelTxn = 0;
    endtask

    // One clock cycle: drive inputs, compare against the model, then advance the model.
    task automatic applyStimulus(input bit w, input logic [NS-1:0] r, input bit rn);
        bit            stTail;
        bit            inHold;
        bit            allDone;
        bit            mJoin;
        bit            expFull;
        logic [NS-1:0] expEmpty;
        logic [NS-1:0] acc;
        @(negedge clk);
        ctrl.if_write = w;
        ctrl.if_read  = r;
        reset_n       = rn;
        #1;
        stTail  = (writeHist.size() >= TL) ? writeHist[writeHist.size()-TL] : 1'b0;
        expFull = (joinHist.size() >= TL) ? joinHist[joinHist.size()-TL] : 1'b0;
        inHold  = (cycleNo - lastJoin) <= GP;
        allDone = 1'b1;
        for (int i = 0; i < NS; i++) begin
            expEmpty[i] = stTail && !inHold && !modelDone[i];
            acc[i]      = r[i] && expEmpty[i];
            if (!(modelDone[i] || acc[i])) allDone = 1'b0;
        end
        mJoin = !inHold && allDone;
        if (checksOn) begin
            checkOutput("if_empty_n", 32'(ctrl.if_empty_n), 32'(expEmpty));
            checkOutput("if_full_n", 32'(ctrl.if_full_n), 32'(expFull));
            checkOutput("err_unexpected_ready", 32'(errOut), 32'(modelErr));
            checkOutput("txn_count", 32'(txnOut), 32'(modelTxn));
        end
        if (!rn) begin
            modelReset();
        end else begin
            writeHist.push_back(w);
            joinHist.push_back(mJoin);
            if ((r & ~expEmpty) != '0) modelErr = 1'b1;
            if (mJoin) begin
                for (int i = 0; i < NS; i++) modelDone[i] = 1'b0;
                lastJoin = cycleNo;
                modelTxn = (modelTxn + 1) % (1 << CW);
            end else begin
                for (int i = 0; i < NS; i++) if (acc[i]) modelDone[i] = 1'b1;
            end
        end
        cycleNo++;
    endtask

    initial begin
        int            pulseCount;
        int            pulseCycle;
        logic [NS-1:0] rd;
        bit            wr;
        bit            rst;
        ctrl.if_write = 1'b0;
        ctrl.if_read  = '0;
        reset_n       = 1'b0;
        pulseCount    = 0;
        pulseCycle    = -1;

        applyStimulus(1'b0, '0, 1'b0);
        applyStimulus(1'b0, '0, 1'b0);
        checksOn = 1'b1;

        // Staggered join, stray ready in HOLD, then reset while a join is still in flight.
        for (int d = 0; d < 24; d++) begin
            rd = '0;
            case (d)
                4:  rd = 3'b001;
                6:  rd = 3'b100;
                9:  rd = 3'b010;
                11: rd = 3'b001;
                16: rd = 3'b111;
                default: rd = '0;
            endcase
            applyStimulus(d < 18, rd, d != 17);
            if (ctrl.if_full_n) begin
                pulseCount++;
                pulseCycle = d;
            end
            if (d == 5)  checkOutput("stagger_d5", 32'(ctrl.if_empty_n), 32'b110);
            if (d == 7)  checkOutput("stagger_d7", 32'(ctrl.if_empty_n), 32'b010);
            if (d == 12) checkOutput("hold_empty", 32'(ctrl.if_empty_n), 32'b000);
            if (d == 12) checkOutput("txn_after_join", 32'(txnOut), 32'd1);
            if (d == 14) checkOutput("hold_end", 32'(ctrl.if_empty_n), 32'b111);
            if (d == 15) checkOutput("hold_err", 32'(errOut), 32'd1);
            if (d == 18) checkOutput("post_reset_txn", 32'(txnOut), 32'd0);
            if (d == 18) checkOutput("post_reset_err", 32'(errOut), 32'd0);
        end
        checkOutput("directed_pulses", 32'(pulseCount), 32'd1);
        checkOutput("directed_pulse_cycle", 32'(pulseCycle), 32'd11);

        // Random traffic with occasional resets; CW=3 makes txn_count wrap repeatedly.
        for (int n = 0; n < 3000; n++) begin
            wr  = ($urandom_range(0, 9) != 0);
            for (int i = 0; i < NS; i++) rd[i] = ($urandom_range(0, 2) == 0);
            rst = ($urandom_range(0, 299) == 0);
            applyStimulus(wr, rd, !rst);
        end

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/rs_ap_ctrl_join_tail.md
# rs_ap_ctrl_join_tail

Parametrised ap_ctrl tail for pipelined control paths: carries an upstream ap_start through TAIL_LEVEL register stages, broadcasts it to NUM_SINKS sink modules, and joins their individual ap_ready handshakes into one ap_ready returned upstream through a matching TAIL_LEVEL-stage pipeline. After each join, all sinks' ap_start is suppressed for GRACE_PERIOD cycles so that the pipelined ap_start, which goes low late, cannot retrigger a sink. It sits at the sink end of an ap_ctrl relay chain between a floorplanned upstream controller and one or more dataflow sink modules.

## Interface
- GRACE_PERIOD, default 4: number of hold cycles after each join. Must satisfy GRACE_PERIOD ≥ max(1, 2*TAIL_LEVEL); otherwise elaboration aborts with $error.
- TAIL_LEVEL, default 1: register stages on each of the ap_start and ap_ready paths, range 0..8. A value of 0 gives a combinational path from if_read to if_full_n.
- NUM_SINKS, default 1: number of sink modules, range 1..16.
- COUNT_WIDTH, default 16: width of txn_count.
- __REGION, default "": floorplan tag with no functional effect.
- clk  input  1  clock; all logic is on the rising edge.
- reset_n  input  1  synchronous reset, active-low.
- if_write  input  1  upstream ap_start, held high until if_full_n is seen.
- if_full_n  output  1  upstream ap_ready, a one-cycle pulse per completed transaction.
- if_empty_n  output  NUM_SINKS  per-sink ap_start.
- if_read  input  NUM_SINKS  per-sink ap_ready.
- err_unexpected_ready  output  1  sticky flag; cleared only by reset.
- txn_count  output  COUNT_WIDTH  number of completed joins; wraps modulo 2^COUNT_WIDTH.

## Operation
- start_pipe is a TAIL_LEVEL-deep shift register of if_write. Its last stage is start_tail. When TAIL_LEVEL = 0, start_tail = if_write.
- ready_pipe is a TAIL_LEVEL-deep shift register of join. if_full_n is its last stage. When TAIL_LEVEL = 0, if_full_n = join.
- done[NUM_SINKS-1:0] records the sinks that have completed the current transaction.
- The block has two states: COLLECT and HOLD. The counter is $clog2(GRACE_PERIOD+1) bits wide.
- Sink start: if_empty_n[i] = start_tail & (state == COLLECT) & ~done[i].
- Sink completion: accept[i] = if_read[i] & if_empty_n[i].
- Join condition: join = (state == COLLECT) & &(done | accept), evaluated combinationally.
- In COLLECT without join: done[i] <= 1 for every accepted sink.
- In COLLECT with join:
  - done <= 0.
  - state <= HOLD, counter <= 1.
  - txn_count <= txn_count + 1.
- In HOLD:
  - if counter == GRACE_PERIOD, then state <= COLLECT and counter <= 0;
  - otherwise counter increments.
- Unexpected ready: if_read[i] high while if_empty_n[i] is low (during HOLD, after done[i] is set, or with start_tail low) is ignored and sets err_unexpected_ready. It does not restart the HOLD counter.
- Reset (reset_n = 0 at a clock edge) clears:
  - both pipes;
  - done and counter, and sets state to COLLECT;
  - err_unexpected_ready and txn_count.
- Reset effect on outputs from the next cycle: if_full_n = 0, if_empty_n = 0, err_unexpected_ready = 0, txn_count = 0.
- Reset mid-transaction: pending joins in ready_pipe are discarded and upstream never receives ap_ready for that transaction. Upstream must itself be reset or restart.

## Timing
- Start latency: if_write rising at cycle t gives if_empty_n high at t+TAIL_LEVEL, provided state is COLLECT.
- Join latency: join at cycle j gives if_full_n = 1 during cycle j+TAIL_LEVEL only.
- Upstream ap_start drop: an upstream that drops if_write at j+TAIL_LEVEL+1 is seen as start_tail low at j+2*TAIL_LEVEL+1.
- Hold window: HOLD covers cycles j+1 .. j+GRACE_PERIOD, and COLLECT resumes at j+GRACE_PERIOD+1. No sink ever sees a stale ap_start.
- Back-to-back transactions: if if_write stays high, the next if_empty_n assertion is at j+GRACE_PERIOD+1.
- Simultaneous completion: all sinks ready in the same cycle produces join in that cycle.
- Mixed completion: sinks that are ready earlier drop their if_empty_n the cycle after their accept, while the other sinks keep theirs.
- Counter wrap: txn_count goes from 2^COUNT_WIDTH-1 to 0 with no flag.

## Test plan
- Basic single-sink case (NUM_SINKS=1, TAIL_LEVEL=1, GRACE_PERIOD=4):
  - stimulus: if_write high at cycle 0, sink asserts if_read at cycle 3;
  - required: if_empty_n high over cycles 1–3; if_full_n pulse at cycle 4; if_empty_n low over cycles 4–7 even with if_write held; if_empty_n high again at cycle 8; txn_count = 1.
- Staggered join (NUM_SINKS=3, TAIL_LEVEL=2, GRACE_PERIOD=4):
  - stimulus: if_read[0] at cycle 4, if_read[2] at cycle 6, if_read[1] at cycle 9;
  - required: if_empty_n[0] low from cycle 5, if_empty_n[2] low from cycle 7; single if_full_n pulse at cycle 11; txn_count = 1.
- Ready during hold:
  - stimulus: pulse if_read[0] in the second HOLD cycle;
  - required: no new join; err_unexpected_ready = 1 and stays high; HOLD still ends on schedule.
- Parameter check: GRACE_PERIOD=3 with TAIL_LEVEL=2 → elaboration error.
- Mid-transaction reset:
  - stimulus: assert reset_n = 0 for one cycle while the join pulse is inside ready_pipe;
  - required: if_full_n never pulses; all outputs are 0 the next cycle; txn_count = 0.
- Counter wrap:
  - stimulus: COUNT_WIDTH=2, run 5 transactions back-to-back;
  - required: txn_count sequence 1,2,3,0,1, with one if_full_n pulse per transaction.
